serial_subtractor: RTL

- Bit-serial N-bit subtractor computing D = A − B − bin, one bit per clock, LSB first, using a single borrow flip-flop.
- Area-lean counterpart to the combinational ripple adder for datapaths where latency is acceptable.
- Sits behind a start/ready/done handshake and reports a borrow-out plus zero and signed-overflow flags.

---
 rtl/serial_subtractor.sv | 133 +++++++++++++
 1 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial N-bit subtractor: d = a - b - bin, one bit per clock, LSB first.
// Start/ready/done handshake; results are registered and held until the next completion.
module serial_subtractor #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         bin,
    output logic         ready,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] d,
    output logic         bout,
    output logic         zero,
    output logic         ovf
);

    localparam int CW = (N > 2) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(N - 1);

    localparam logic [1:0] S_IDLE  = 2'b00;
    localparam logic [1:0] S_SHIFT = 2'b01;
    localparam logic [1:0] S_DONE  = 2'b10;

    logic [1:0]    state_reg, state_next;
    logic [N-1:0]  a_reg, b_reg, res_reg;
    logic [N-1:0]  a_shr, b_shr, res_next;
    logic          a_msb_reg, b_msb_reg;
    logic          br_reg, br_next;
    logic [CW-1:0] cnt_reg;
    logic          a_bit, b_bit, diff_bit;
    logic          accept, last_bit;

    logic [N-1:0]  d_reg;
    logic          bout_reg, zero_reg, ovf_reg;

    assign a_bit    = a_reg[0];
    assign b_bit    = b_reg[0];
    assign diff_bit = a_bit ^ b_bit ^ br_reg;
    assign br_next  = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & br_reg);

    assign accept   = (state_reg == S_IDLE) && start;
    assign last_bit = (state_reg == S_SHIFT) && (cnt_reg == LAST_BIT);

    // Operands shift right to expose the current bit at position 0; the
    // difference enters at the MSB so it lands in place after N shifts.
    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_shift
            if (gi == N - 1) begin : g_top
                assign a_shr[gi]    = 1'b0;
                assign b_shr[gi]    = 1'b0;
                assign res_next[gi] = diff_bit;
            end else begin : g_mid
                assign a_shr[gi]    = a_reg[gi+1];
                assign b_shr[gi]    = b_reg[gi+1];
                assign res_next[gi] = res_reg[gi+1];
            end
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:  if (start) state_next = S_SHIFT;
            S_SHIFT: if (cnt_reg == LAST_BIT) state_next = S_DONE;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_reg     <= '0;
            b_reg     <= '0;
            res_reg   <= '0;
            a_msb_reg <= 1'b0;
            b_msb_reg <= 1'b0;
            br_reg    <= 1'b0;
            cnt_reg   <= '0;
        end else if (accept) begin
            a_reg     <= a;
            b_reg     <= b;
            a_msb_reg <= a[N-1];
            b_msb_reg <= b[N-1];
            br_reg    <= bin;
            cnt_reg   <= '0;
        end else if (state_reg == S_SHIFT) begin
            a_reg   <= a_shr;
            b_reg   <= b_shr;
            res_reg <= res_next;
            br_reg  <= br_next;
            if (!last_bit) begin
                cnt_reg <= cnt_reg + 1'b1;
            end
        end
    end

    // Result registers only move on the edge that completes the final bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d_reg    <= '0;
            bout_reg <= 1'b0;
            zero_reg <= 1'b0;
            ovf_reg  <= 1'b0;
        end else if (last_bit) begin
            d_reg    <= res_next;
            bout_reg <= br_next;
            zero_reg <= (res_next == '0);
            ovf_reg  <= (a_msb_reg ^ b_msb_reg) & (diff_bit ^ a_msb_reg);
        end
    end

    assign ready = (state_reg == S_IDLE);
    assign busy  = (state_reg == S_SHIFT);
    assign done  = (state_reg == S_DONE);
    assign d     = d_reg;
    assign bout  = bout_reg;
    assign zero  = zero_reg;
    assign ovf   = ovf_reg;

endmodule
